// File: rtl/pipo_shift_ctrl.sv
// Parallel-in/parallel-out shift register with its sequencing controller:
// accept a word and a shift command, step one bit per clock, hand the result on.
module pipo_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3,
    parameter int OPS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [OPS_W-1:0] ops_done,
    output logic [1:0]       o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1. Ready never depends on valid; the source holds its payload stable
    // while valid=1 and ready=0, and the controller holds out_data while out_valid=1.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [OPS_W-1:0] OPS_ONE = OPS_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_rot;
    logic [OPS_W-1:0] r_ops;
    logic             w_fill;
    logic [WIDTH-1:0] w_shifted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = (in_amt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_ONE) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Rotate refills the vacated end with the bit that just fell off the other end.
    always_comb begin
        w_fill    = 1'b0;
        w_shifted = r_data;
        if (r_rot) begin
            w_fill = r_dir ? r_data[0] : r_data[WIDTH-1];
        end
        if (r_dir) begin
            w_shifted = {w_fill, r_data[WIDTH-1:1]};
        end else begin
            w_shifted = {r_data[WIDTH-2:0], w_fill};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
            r_rot  <= 1'b0;
            r_ops  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data <= in_data;
                        r_cnt  <= in_amt;
                        r_dir  <= in_dir;
                        r_rot  <= in_rot;
                    end
                end
                S_SHIFT: begin
                    r_data <= w_shifted;
                    r_cnt  <= r_cnt - CNT_ONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_ops <= r_ops + OPS_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign busy        = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign out_data    = r_data;
    assign ops_done    = r_ops;
    assign o_dbg_state = r_state;

endmodule
